// File: rtl/host_bus_responder_pkg.sv
// Shared state encoding and default widths for the host bus responder.
package host_bus_responder_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 6;
    localparam int unsigned DATA_WIDTH_DEF  = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_FETCH  = 3'd1,
        RD_DRIVE  = 3'd2,
        WR_WAIT   = 3'd3,
        WR_COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/host_bus_responder_bus_synchronizer.sv
// Multi-flop synchroniser for an active-low asynchronous control line.
// The chain presets to 1 so the line reads inactive out of reset.
module host_bus_responder_bus_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the chain; preset to inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/host_bus_responder.sv
// Responder for the asynchronous host CPU bus: synchronises the control
// strobes and turns each bus cycle into one register-file read or write pulse.
// SYNC_STAGES must be 2 or more.
module host_bus_responder
    import host_bus_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_ncs,
    input  logic                  bus_nrd,
    input  logic                  bus_nwr,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_wr_strobe,
    output logic                  reg_rd_strobe,
    input  logic [DATA_WIDTH-1:0] reg_rd_data
);

    logic   ncs_s;
    logic   nrd_s;
    logic   nwr_s;
    logic   rd;
    logic   wr;
    logic   armed;
    state_t state;

    host_bus_responder_bus_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk   (clk),
        .reset (reset),
        .d     (bus_ncs),
        .q     (ncs_s)
    );

    host_bus_responder_bus_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_nrd (
        .clk   (clk),
        .reset (reset),
        .d     (bus_nrd),
        .q     (nrd_s)
    );

    host_bus_responder_bus_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_nwr (
        .clk   (clk),
        .reset (reset),
        .d     (bus_nwr),
        .q     (nwr_s)
    );

    assign rd = !ncs_s && !nrd_s;
    assign wr = !ncs_s && !nwr_s;

    // Bus-cycle FSM; armed gates IDLE so a strobe must be seen idle before it can start a new cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            armed         <= 1'b0;
            bus_data_out  <= '0;
            bus_data_oe   <= 1'b0;
            reg_addr      <= '0;
            reg_wr_data   <= '0;
            reg_wr_strobe <= 1'b0;
            reg_rd_strobe <= 1'b0;
        end else begin
            reg_wr_strobe <= 1'b0;
            reg_rd_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rd && !wr) begin
                        armed <= 1'b1;
                    end
                    if (armed && rd && !wr) begin
                        armed         <= 1'b0;
                        reg_addr      <= bus_addr;
                        reg_rd_strobe <= 1'b1;
                        state         <= RD_FETCH;
                    end else if (armed && wr && !rd) begin
                        armed <= 1'b0;
                        state <= WR_WAIT;
                    end
                end
                RD_FETCH: begin
                    bus_data_out <= reg_rd_data;
                    bus_data_oe  <= 1'b1;
                    state        <= RD_DRIVE;
                end
                RD_DRIVE: begin
                    if (!rd) begin
                        bus_data_oe <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wr) begin
                        reg_addr    <= bus_addr;
                        reg_wr_data <= bus_data_in;
                    end else begin
                        reg_wr_strobe <= 1'b1;
                        state         <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_bus_responder.sv
// Directed bench for host_bus_responder with hand-computed expectations.
module tb_host_bus_responder;

    logic        clk;
    logic        reset;
    logic        bus_ncs;
    logic        bus_nrd;
    logic        bus_nwr;
    logic [5:0]  bus_addr;
    logic [15:0] bus_data_in;
    logic [15:0] bus_data_out;
    logic        bus_data_oe;
    logic [5:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_strobe;
    logic        reg_rd_strobe;
    logic [15:0] reg_rd_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          oe_cnt = 0;
    logic [5:0]  rd_addr_log[$];
    logic [5:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    int          rd0;
    int          wr0;
    int          oe0;
    int          q0;

    host_bus_responder dut (
        .clk           (clk),
        .reset         (reset),
        .bus_ncs       (bus_ncs),
        .bus_nrd       (bus_nrd),
        .bus_nwr       (bus_nwr),
        .bus_addr      (bus_addr),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .bus_data_oe   (bus_data_oe),
        .reg_addr      (reg_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_rd_strobe (reg_rd_strobe),
        .reg_rd_data   (reg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record strobes and output-enable activity mid-cycle.
    always @(negedge clk) begin
        if (reg_rd_strobe) begin
            rd_cnt++;
            rd_addr_log.push_back(reg_addr);
        end
        if (reg_wr_strobe) begin
            wr_cnt++;
            last_wr_addr = reg_addr;
            last_wr_data = reg_wr_data;
        end
        if (bus_data_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        bus_ncs     = 1'b1;
        bus_nrd     = 1'b1;
        bus_nwr     = 1'b1;
        bus_addr    = '0;
        bus_data_in = '0;
        reg_rd_data = '0;
        tick(3);
        check("rst_oe",     32'(bus_data_oe),   32'h0);
        check("rst_dout",   32'(bus_data_out),  32'h0);
        check("rst_rdstb",  32'(reg_rd_strobe), 32'h0);
        check("rst_wrstb",  32'(reg_wr_strobe), 32'h0);
        check("rst_addr",   32'(reg_addr),      32'h0);
        check("rst_wdata",  32'(reg_wr_data),   32'h0);
        reset = 1'b0;
        tick(4);

        // Single read: strobe on 3rd edge, oe on 4th, data held, release after 3 edges.
        rd0 = rd_cnt;
        reg_rd_data = 16'hA55A;
        bus_addr    = 6'h12;
        bus_ncs     = 1'b0;
        bus_nrd     = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 2) check("rd_stb_early", 32'(reg_rd_strobe), 32'h0);
            if (i == 3) begin
                check("rd_stb",      32'(reg_rd_strobe), 32'h1);
                check("rd_addr",     32'(reg_addr),      32'h12);
                check("rd_oe_early", 32'(bus_data_oe),   32'h0);
            end
            if (i == 4) begin
                check("rd_oe",     32'(bus_data_oe),   32'h1);
                check("rd_dout",   32'(bus_data_out),  32'hA55A);
                check("rd_stb_1c", 32'(reg_rd_strobe), 32'h0);
            end
            if (i == 5) reg_rd_data = 16'h0000;
        end
        check("rd_dout_hold", 32'(bus_data_out), 32'hA55A);
        bus_nrd = 1'b1;
        bus_ncs = 1'b1;
        tick(2);
        check("rd_oe_rel_early", 32'(bus_data_oe), 32'h1);
        tick(1);
        check("rd_oe_rel", 32'(bus_data_oe), 32'h0);
        tick(3);
        check("rd_count", 32'(rd_cnt - rd0), 32'h1);

        // Write with data changing two cycles before release.
        wr0 = wr_cnt;
        bus_addr    = 6'h05;
        bus_data_in = 16'h1234;
        bus_ncs     = 1'b0;
        bus_nwr     = 1'b0;
        tick(6);
        bus_data_in = 16'hFFFF;
        tick(2);
        bus_nwr = 1'b1;
        bus_ncs = 1'b1;
        tick(6);
        check("wr_count", 32'(wr_cnt - wr0), 32'h1);
        check("wr_data",  32'(last_wr_data), 32'hFFFF);
        check("wr_addr",  32'(last_wr_addr), 32'h05);

        // Bus fault: both strobes low together.
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
        bus_addr = 6'h3C;
        bus_ncs  = 1'b0;
        bus_nrd  = 1'b0;
        bus_nwr  = 1'b0;
        tick(8);
        bus_ncs = 1'b1;
        bus_nrd = 1'b1;
        bus_nwr = 1'b1;
        tick(4);
        check("fault_rd", 32'(rd_cnt - rd0), 32'h0);
        check("fault_wr", 32'(wr_cnt - wr0), 32'h0);
        check("fault_oe", 32'(oe_cnt - oe0), 32'h0);

        // Reset during RD_DRIVE drops oe asynchronously; then a clean read.
        rd0 = rd_cnt;
        reg_rd_data = 16'h0F0F;
        bus_addr    = 6'h2A;
        bus_ncs     = 1'b0;
        bus_nrd     = 1'b0;
        tick(5);
        check("rst_mid_oe_pre", 32'(bus_data_oe), 32'h1);
        #2;
        reset   = 1'b1;
        bus_nrd = 1'b1;
        bus_ncs = 1'b1;
        #1;
        check("rst_mid_oe_async", 32'(bus_data_oe), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("rst_mid_rdcnt", 32'(rd_cnt - rd0), 32'h1);
        rd0 = rd_cnt;
        reg_rd_data = 16'hBEEF;
        bus_addr    = 6'h33;
        bus_ncs     = 1'b0;
        bus_nrd     = 1'b0;
        tick(6);
        check("post_rst_oe",   32'(bus_data_oe),  32'h1);
        check("post_rst_dout", 32'(bus_data_out), 32'hBEEF);
        check("post_rst_addr", 32'(reg_addr),     32'h33);
        bus_nrd = 1'b1;
        bus_ncs = 1'b1;
        tick(5);
        check("post_rst_rel",  32'(bus_data_oe),  32'h0);
        check("post_rst_cnt",  32'(rd_cnt - rd0), 32'h1);

        // ncs released alone ends the read; held nrd does not retrigger.
        rd0 = rd_cnt;
        bus_addr = 6'h07;
        bus_ncs  = 1'b0;
        bus_nrd  = 1'b0;
        tick(6);
        check("ncs_oe_on", 32'(bus_data_oe), 32'h1);
        bus_ncs = 1'b1;
        tick(2);
        check("ncs_oe_hold", 32'(bus_data_oe), 32'h1);
        tick(1);
        check("ncs_oe_off", 32'(bus_data_oe), 32'h0);
        tick(10);
        check("ncs_rdcnt", 32'(rd_cnt - rd0), 32'h1);
        bus_nrd = 1'b1;
        tick(4);

        // Two reads three cycles apart.
        rd0 = rd_cnt;
        q0  = rd_addr_log.size();
        bus_addr = 6'h01;
        bus_ncs  = 1'b0;
        bus_nrd  = 1'b0;
        tick(5);
        bus_ncs = 1'b1;
        bus_nrd = 1'b1;
        tick(3);
        bus_addr = 6'h02;
        bus_ncs  = 1'b0;
        bus_nrd  = 1'b0;
        tick(5);
        bus_ncs = 1'b1;
        bus_nrd = 1'b1;
        tick(6);
        check("b2b_count", 32'(rd_cnt - rd0), 32'h2);
        if (rd_addr_log.size() >= q0 + 2) begin
            check("b2b_addr0", 32'(rd_addr_log[q0]),     32'h01);
            check("b2b_addr1", 32'(rd_addr_log[q0 + 1]), 32'h02);
        end else begin
            check("b2b_log", 32'(rd_addr_log.size() - q0), 32'h2);
        end
        check("end_oe", 32'(bus_data_oe), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
